// File: rtl/coproc_mmio_regs.sv
// MMIO register block fronting the fuzzy-estimator coprocessor: control/status, operands, MF params.
// Optional wait-timeout watchdog is built when COPROC_TIMEOUT_EN is defined.
module coproc_mmio_regs (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [5:0]   addr,
    input  logic [7:0]   wdata,
    output logic [7:0]   rdata,
    output logic         rd_valid,
    output logic         start,
    output logic         init,
    output logic         reg_mode,
    output logic         dt_mode,
    output logic [7:0]   T_in,
    output logic [7:0]   dT_in,
    output logic [191:0] mf_params,
    input  logic         valid,
    input  logic [7:0]   G_in,
    output logic         irq
);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_RESULT = 6'h02;
    localparam logic [5:0] ADDR_T_IN   = 6'h03;
    localparam logic [5:0] ADDR_DT_IN  = 6'h04;
    localparam logic [5:0] ADDR_MF_LO  = 6'h08;
    localparam logic [5:0] ADDR_MF_HI  = 6'h1F;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        init_q;
    logic        reg_mode_q, dt_mode_q, irq_en_q;
    logic [7:0]  t_in_q, dt_in_q, result_q;
    logic [7:0]  mf_q [24];
    logic        done_q, err_q;
    logic        done_set, err_set;
    logic        timeout_flag;
    logic [7:0]  rdata_q, rd_mux;
    logic        rd_valid_q;

    logic        in_idle;
    logic        wr_ok;
    logic        is_mf_addr;
    logic [4:0]  mf_idx;
    logic        start_req;
    logic        status_rd;

    assign in_idle    = (state_q == IDLE);
    assign wr_ok      = wr_en && in_idle;
    assign is_mf_addr = (addr >= ADDR_MF_LO) && (addr <= ADDR_MF_HI);
    assign mf_idx     = 5'(addr - ADDR_MF_LO);
    assign start_req  = wr_ok && (addr == ADDR_CTRL) && wdata[0];
    assign status_rd  = rd_en && (addr == ADDR_STATUS);
    // CTRL and the whole operand/MF window are locked while the core is evaluating
    assign err_set    = wr_en && !in_idle &&
                        ((addr == ADDR_CTRL) || ((addr >= ADDR_T_IN) && (addr <= ADDR_MF_HI)));

`ifdef COPROC_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_set;
    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // FSM next-state: valid takes priority over the timeout expiry on the same edge
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        done_set = 1'b0;
`ifdef COPROC_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = WAIT;
                    start_d = 1'b1;
`ifdef COPROC_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (valid) begin
                    state_d  = IDLE;
                    start_d  = 1'b0;
                    done_set = 1'b1;
                end
`ifdef COPROC_TIMEOUT_EN
                else if (wait_cnt_q == 8'd63) begin
                    state_d     = IDLE;
                    start_d     = 1'b0;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

`ifdef COPROC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_set | (timeout_q & ~status_rd);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            reg_mode_q <= 1'b0;
            dt_mode_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            t_in_q     <= '0;
            dt_in_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < 24; i++) begin
                mf_q[i] <= '0;
            end
        end else begin
            init_q <= wr_ok && (addr == ADDR_CTRL) && wdata[1];
            if (wr_ok) begin
                case (addr)
                    ADDR_CTRL: begin
                        reg_mode_q <= wdata[2];
                        dt_mode_q  <= wdata[3];
                        irq_en_q   <= wdata[7];
                    end
                    ADDR_T_IN:  t_in_q  <= wdata;
                    ADDR_DT_IN: dt_in_q <= wdata;
                    default: begin
                        if (is_mf_addr) begin
                            mf_q[mf_idx] <= wdata;
                        end
                    end
                endcase
            end
            if (done_set) begin
                result_q <= G_in;
            end
            // A flag being set on the same edge as a STATUS read survives the clear
            done_q <= done_set | (done_q & ~status_rd);
            err_q  <= err_set  | (err_q  & ~status_rd);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_CTRL:   rd_mux = {irq_en_q, 3'b000, dt_mode_q, reg_mode_q, 2'b00};
            ADDR_STATUS: rd_mux = {4'b0000, err_q, timeout_flag, done_q, ~in_idle};
            ADDR_RESULT: rd_mux = result_q;
            ADDR_T_IN:   rd_mux = t_in_q;
            ADDR_DT_IN:  rd_mux = dt_in_q;
            default: begin
                if (is_mf_addr) begin
                    rd_mux = mf_q[mf_idx];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_mux;
            end
        end
    end

    always_comb begin
        mf_params = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            mf_params[8*i +: 8] = mf_q[i];
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign start    = start_q;
    assign init     = init_q;
    assign reg_mode = reg_mode_q;
    assign dt_mode  = dt_mode_q;
    assign T_in     = t_in_q;
    assign dT_in    = dt_in_q;
    assign irq      = irq_en_q & (done_q | timeout_flag);

endmodule
